// File: rtl/minmax_seq.sv
// Sequential batch min/max/count tracker. A single signed less-than comparator
// is shared between the min and max updates, one per cycle.
module minmax_slt #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);
  assign lt_o = $signed(a_i) < $signed(b_i);
endmodule

module minmax_seq #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_min,
  output logic [N-1:0]  out_max,
  output logic [CW-1:0] out_count,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, ACCEPT, CMP_MIN, CMP_MAX, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  min_q, min_d, max_q, max_d, samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d, first_q, first_d;
  logic [N-1:0]  cmp_a, cmp_b;
  logic          cmp_lt;

  minmax_slt #(.N(N)) u_slt (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .lt_o (cmp_lt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      samp_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    first_d = first_q;
    cmp_a   = samp_q;
    cmp_b   = min_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCEPT;
          min_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          samp_d = in_data;
          last_d = in_last;
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          if (first_q) begin
            min_d   = in_data;
            max_d   = in_data;
            first_d = 1'b0;
            state_d = in_last ? DONE : ACCEPT;
          end else begin
            state_d = CMP_MIN;
          end
        end
      end
      CMP_MIN: begin
        cmp_a = samp_q;
        cmp_b = min_q;
        if (cmp_lt) min_d = samp_q;
        state_d = CMP_MAX;
      end
      CMP_MAX: begin
        // Operands swapped so the same a<b comparator answers max<sample.
        cmp_a = max_q;
        cmp_b = samp_q;
        if (cmp_lt) max_d = samp_q;
        state_d = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACCEPT);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;
endmodule
